// File: rtl/mem_access_stage_if.sv
// Bundle of the memory-access stage's three channels:
//   ex_*   : instruction handoff from execute (valid/ready)
//   dmem_* : data-memory request/grant/response handshake
//   wb_*   : retire pulse to writeback (no backpressure)
// Modport slave is the stage's view; master is the surrounding environment's view.
interface mem_access_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_result;
  logic [31:0] ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_wstrb;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mem_err;

  modport slave (
    input  ex_valid, ex_result, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_funct3,
    output ex_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata,
    output wb_valid, wb_we, wb_rd, wb_data, mem_err
  );

  modport master (
    output ex_valid, ex_result, ex_rs2, ex_rd, ex_reg_write, ex_mem_read,
           ex_mem_write, ex_funct3,
    input  ex_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata,
    input  wb_valid, wb_we, wb_rd, wb_data, mem_err
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage: forwards ALU results for non-memory ops, runs the
// request/grant/response handshake with data memory for loads and stores,
// aligns byte lanes and extends load data. Execute is stalled (ex_ready=0)
// while an access is in flight.
// Ports: clk, rst_n (async, active-low), bus (mem_access_stage_if.slave:
// ex_* handoff, dmem_* memory handshake, wb_* retire pulse + mem_err).
module mem_access_stage (
  input logic                 clk,
  input logic                 rst_n,
  mem_access_stage_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [2:0]  f3_q, f3_d;
  logic        rw_q, rw_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] wdata_q, wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        mem_err_q, mem_err_d;

  logic        is_mem, ld_f3_ok, st_f3_ok, misalign, acc_err;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b100:  load_extend = {24'd0, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

  // Returns {wstrb, wdata} with the store data replicated across every lane
  // so memory can pick it up from whichever lane the strobe selects.
  function automatic logic [35:0] store_lanes(input logic [31:0] rs2,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
    case (f3[1:0])
      2'b00:   store_lanes = {4'b0001 << lane, {4{rs2[7:0]}}};
      2'b01:   store_lanes = {lane[1] ? 4'b1100 : 4'b0011, {2{rs2[15:0]}}};
      default: store_lanes = {4'b1111, rs2};
    endcase
  endfunction

  assign is_mem   = bus.ex_mem_read | bus.ex_mem_write;
  assign ld_f3_ok = (bus.ex_funct3 == 3'b000) || (bus.ex_funct3 == 3'b001) ||
                    (bus.ex_funct3 == 3'b010) || (bus.ex_funct3 == 3'b100) ||
                    (bus.ex_funct3 == 3'b101);
  assign st_f3_ok = !bus.ex_funct3[2] && (bus.ex_funct3[1:0] != 2'b11);
  assign misalign = ((bus.ex_funct3[1:0] == 2'b01) && bus.ex_result[0]) ||
                    ((bus.ex_funct3[1:0] == 2'b10) && (bus.ex_result[1:0] != 2'b00));
  assign acc_err  = (bus.ex_mem_read && bus.ex_mem_write) ||
                    (bus.ex_mem_read && !ld_f3_ok) ||
                    (bus.ex_mem_write && !st_f3_ok) || misalign;

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    f3_d       = f3_q;
    rw_d       = rw_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wstrb_d    = wstrb_q;
    wdata_d    = wdata_q;
    wb_valid_d = 1'b0;
    wb_we_d    = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    mem_err_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.ex_valid) begin
          lane_d  = bus.ex_result[1:0];
          f3_d    = bus.ex_funct3;
          rw_d    = bus.ex_reg_write;
          wb_rd_d = bus.ex_rd;
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_we_d    = bus.ex_reg_write && (bus.ex_rd != 5'd0);
            wb_data_d  = bus.ex_result;
          end else if (acc_err) begin
            wb_valid_d = 1'b1;
            mem_err_d  = 1'b1;
          end else begin
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = bus.ex_mem_write;
            addr_d  = {bus.ex_result[31:2], 2'b00};
            {wstrb_d, wdata_d} = bus.ex_mem_write ?
              store_lanes(bus.ex_rs2, bus.ex_result[1:0], bus.ex_funct3) : 36'd0;
          end
        end
      end
      REQ: begin
        if (bus.dmem_gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            // Store completes on grant; nothing is written back.
            state_d    = IDLE;
            wb_valid_d = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (bus.dmem_rvalid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_we_d    = rw_q && (wb_rd_q != 5'd0);
          wb_data_d  = load_extend(bus.dmem_rdata, lane_q, f3_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered stage boundary: every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lane_q     <= 2'd0;
      f3_q       <= 3'd0;
      rw_q       <= 1'b0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wstrb_q    <= 4'd0;
      wdata_q    <= 32'd0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      f3_q       <= f3_d;
      rw_q       <= rw_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wstrb_q    <= wstrb_d;
      wdata_q    <= wdata_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign bus.ex_ready   = (state_q == IDLE);
  assign bus.dmem_req   = req_q;
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wstrb = wstrb_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.wb_valid   = wb_valid_q;
  assign bus.wb_we      = wb_we_q;
  assign bus.wb_rd      = wb_rd_q;
  assign bus.wb_data    = wb_data_q;
  assign bus.mem_err    = mem_err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: expected retire records are queued when an
// instruction is driven and compared when wb_valid pulses.
module tb_mem_access_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_stage_if bus ();

  mem_access_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        we;
    logic [31:0] data;
    logic        chk_data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
  endtask

  // Retire monitor: every wb pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.wb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("wb_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_rd", {27'd0, bus.wb_rd}, {27'd0, e.rd});
        chk("wb_we", {31'd0, bus.wb_we}, {31'd0, e.we});
        chk("mem_err", {31'd0, bus.mem_err}, {31'd0, e.err});
        if (e.chk_data) chk("wb_data", bus.wb_data, e.data);
      end
    end
  end

  task automatic push(input logic [4:0] rd, input logic we, input logic [31:0] data,
                      input logic chk_data, input logic err);
    exp_t e;
    e.rd = rd; e.we = we; e.data = data; e.chk_data = chk_data; e.err = err;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1 with the stage idle; presents one instruction for one edge.
  task automatic drive(input logic [31:0] res, input logic [31:0] rs2, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic mw, input logic [2:0] f3);
    bus.ex_valid     = 1'b1;
    bus.ex_result    = res;
    bus.ex_rs2       = rs2;
    bus.ex_rd        = rd;
    bus.ex_reg_write = rw;
    bus.ex_mem_read  = mr;
    bus.ex_mem_write = mw;
    bus.ex_funct3    = f3;
    @(posedge clk); #1;
    bus.ex_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("drain", exp_q.size(), 32'd0);
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] rs2,
                          input int hold, input logic [3:0] wstrb, input logic [31:0] wdata);
    push(5'd9, 1'b0, 32'd0, 1'b0, 1'b0);
    drive(addr, rs2, 5'd9, 1'b0, 1'b0, 1'b1, f3);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      chk("st_req", {31'd0, bus.dmem_req}, 32'd1);
      chk("st_we", {31'd0, bus.dmem_we}, 32'd1);
      chk("st_addr", bus.dmem_addr, {addr[31:2], 2'b00});
      chk("st_wstrb", {28'd0, bus.dmem_wstrb}, {28'd0, wstrb});
      chk("st_wdata", bus.dmem_wdata, wdata);
      chk("st_stall", {31'd0, bus.ex_ready}, 32'd0);
      if (i == hold) bus.dmem_gnt = 1'b1;
    end
    @(posedge clk); #1;
    bus.dmem_gnt = 1'b0;
    wait_drain();
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                         input logic rw, input logic [31:0] rdata, input logic [31:0] exp_data);
    push(rd, rw && (rd != 5'd0), exp_data, 1'b1, 1'b0);
    drive(addr, 32'd0, rd, rw, 1'b1, 1'b0, f3);
    @(negedge clk);
    chk("ld_req", {31'd0, bus.dmem_req}, 32'd1);
    chk("ld_we", {31'd0, bus.dmem_we}, 32'd0);
    chk("ld_wstrb", {28'd0, bus.dmem_wstrb}, 32'd0);
    chk("ld_addr", bus.dmem_addr, {addr[31:2], 2'b00});
    bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rdata  = rdata;
    bus.dmem_rvalid = 1'b1;
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;
    wait_drain();
  endtask

  task automatic do_err(input logic [31:0] addr, input logic mr, input logic mw,
                        input logic [2:0] f3);
    push(5'd3, 1'b0, 32'd0, 1'b0, 1'b1);
    drive(addr, 32'hFFFF_FFFF, 5'd3, 1'b1, mr, mw, f3);
    @(negedge clk);
    chk("err_no_req", {31'd0, bus.dmem_req}, 32'd0);
    wait_drain();
  endtask

  initial begin
    bus.ex_valid = 1'b0; bus.ex_result = '0; bus.ex_rs2 = '0; bus.ex_rd = '0;
    bus.ex_reg_write = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_mem_write = 1'b0;
    bus.ex_funct3 = '0; bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b0; bus.dmem_rdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rst_mem_err", {31'd0, bus.mem_err}, 32'd0);
    chk("rst_wstrb", {28'd0, bus.dmem_wstrb}, 32'd0);
    chk("rst_addr", bus.dmem_addr, 32'd0);
    chk("rst_wb_data", bus.wb_data, 32'd0);
    chk("rst_ready", {31'd0, bus.ex_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back non-memory ops, one retire per cycle.
    push(5'd5, 1'b1, 32'h0000_1234, 1'b1, 1'b0);
    drive(32'h0000_1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    push(5'd0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    drive(32'hFFFF_FFFF, 32'd0, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
    @(negedge clk);
    chk("nm_b2b", {31'd0, bus.wb_valid}, 32'd1);
    wait_drain();

    // Stores.
    do_store(32'h0000_0103, 3'b000, 32'hAABB_CCDD, 3, 4'b1000, 32'hDDDD_DDDD);
    do_store(32'h0000_0106, 3'b001, 32'h1122_3344, 0, 4'b1100, 32'h3344_3344);
    do_store(32'h0000_0108, 3'b010, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D);

    // Loads with lane selection and extension.
    do_load(32'h0000_0202, 3'b000, 5'd6, 1'b1, 32'h0080_0000, 32'hFFFF_FF80);
    do_load(32'h0000_0202, 3'b100, 5'd7, 1'b1, 32'h0080_0000, 32'h0000_0080);
    do_load(32'h0000_0202, 3'b001, 5'd8, 1'b1, 32'h8001_0000, 32'hFFFF_8001);
    do_load(32'h0000_0200, 3'b101, 5'd8, 1'b1, 32'h0000_F00F, 32'h0000_F00F);
    do_load(32'h0000_0204, 3'b010, 5'd0, 1'b1, 32'h1234_5678, 32'h1234_5678);

    // Illegal and misaligned accesses.
    do_err(32'h0000_0301, 1'b1, 1'b0, 3'b010);
    do_err(32'h0000_0305, 1'b0, 1'b1, 3'b001);
    do_err(32'h0000_0300, 1'b1, 1'b1, 3'b010);
    do_err(32'h0000_0300, 1'b1, 1'b0, 3'b011);

    // rvalid during REQ must be ignored; data comes from the WAIT-cycle rvalid.
    push(5'd10, 1'b1, 32'h0000_00AB, 1'b1, 1'b0);
    drive(32'h0000_0400, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b010);
    bus.dmem_rdata = 32'hDEAD_BEEF; bus.dmem_rvalid = 1'b1;
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0; bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.dmem_gnt = 1'b0;
    @(posedge clk); #1;
    bus.dmem_rdata = 32'h0000_00AB; bus.dmem_rvalid = 1'b1;
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;
    wait_drain();

    // Reset while requesting: request drops asynchronously, stray gnt/rvalid ignored.
    drive(32'h0000_0500, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b010);
    rst_n = 1'b0; #1;
    chk("rstreq_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rstreq_ready", {31'd0, bus.ex_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.dmem_gnt = 1'b0; bus.dmem_rvalid = 1'b1;
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Reset while waiting for load data.
    drive(32'h0000_0600, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0, 3'b010);
    bus.dmem_gnt = 1'b1;
    @(posedge clk); #1;
    bus.dmem_gnt = 1'b0;
    rst_n = 1'b0; #1;
    chk("rstwait_req", {31'd0, bus.dmem_req}, 32'd0);
    chk("rstwait_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
    chk("rstwait_addr", bus.dmem_addr, 32'd0);
    chk("rstwait_wb_data", bus.wb_data, 32'd0);
    chk("rstwait_ready", {31'd0, bus.ex_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    bus.dmem_rdata = 32'h5555_5555; bus.dmem_rvalid = 1'b1;
    @(posedge clk); #1;
    bus.dmem_rvalid = 1'b0;
    repeat (3) @(posedge clk); #1;

    // Recovery after reset.
    push(5'd13, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0);
    drive(32'h0BAD_F00D, 32'd0, 5'd13, 1'b1, 1'b0, 1'b0, 3'b000);
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage directly downstream of the ALU, and the owner of all load/store traffic to data memory. Accepts one executed instruction at a time from the execute stage: the ALU result, store data, destination register and memory-op control. For non-memory ops it forwards the ALU result to writeback. For loads and stores it runs a request/grant/response handshake with data memory, performs byte-lane alignment and load sign/zero extension, and stalls the execute stage until the access completes.

## Interface
Parameters: none (XLEN fixed at 32, 5-bit register index).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- ex_valid  in  1  execute stage presents an instruction
- ex_ready  out  1  stage can accept; transfer when ex_valid && ex_ready
- ex_result  in  32  ALU result: effective address for loads/stores, write value otherwise
- ex_rs2  in  32  store data
- ex_rd  in  5  destination register
- ex_reg_write  in  1  instruction writes rd
- ex_mem_read  in  1  load
- ex_mem_write  in  1  store
- ex_funct3  in  3  access size/sign (RV32I encoding)
- dmem_req  out  1  memory request, held until granted
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address {ex_result[31:2],2'b00}
- dmem_wstrb  out  4  byte enables (0000 for loads)
- dmem_wdata  out  32  lane-replicated store data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load word
- wb_valid  out  1  one-cycle pulse: instruction retired to writeback
- wb_we  out  1  register-file write enable, qualified by wb_valid
- wb_rd  out  5  destination register
- wb_data  out  32  write value
- mem_err  out  1  with wb_valid: misaligned or illegal access, no write performed

## Operation
- FSM states: IDLE, REQ, WAIT. ex_ready = (state == IDLE).
- IDLE, on accept, the instruction is latched and classified:
  - Non-memory op: the next cycle gives wb_valid=1, wb_data=ex_result, wb_we=ex_reg_write. State stays IDLE.
  - Error: the next cycle gives wb_valid=1, mem_err=1, wb_we=0, and no dmem_req. State stays IDLE. Error cases:
    - ex_mem_read and ex_mem_write both set.
    - Load funct3 outside {000,001,010,100,101}, or store funct3 outside {000,001,010}.
    - Halfword access with addr[0]=1, or word access with addr[1:0]≠0.
  - Valid load or store: go to REQ.
- REQ: dmem_req=1; addr, we, wstrb and wdata are held stable until dmem_gnt.
  - On gnt, a store goes to IDLE with wb_valid=1, wb_we=0 on the next cycle.
  - On gnt, a load goes to WAIT.
- WAIT: dmem_rvalid is sampled only in this state.
  - On rvalid, go to IDLE with wb_valid=1, wb_we=ex_reg_write, and wb_data as follows:
    - LB/LBU: the byte at lane addr[1:0], sign- or zero-extended.
    - LH/LHU: the half at lane addr[1], sign- or zero-extended.
    - LW: the full word.
- Store lanes:
  - SB: wdata = {4{rs2[7:0]}}, wstrb = 0001 << addr[1:0].
  - SH: wdata = {2{rs2[15:0]}}, wstrb = addr[1] ? 1100 : 0011.
  - SW: wdata = rs2, wstrb = 1111.
- rd = 0 forces wb_we = 0 in every case.
- dmem_rvalid outside WAIT and dmem_gnt outside REQ are ignored.

## Timing
- Reset: state=IDLE. dmem_req, dmem_we, wb_valid, wb_we and mem_err are 0. dmem_wstrb=0. dmem_addr, dmem_wdata, wb_rd and wb_data are 0.
- Reset mid-access drops dmem_req asynchronously. Any later gnt/rvalid belonging to the aborted access is ignored.
- All outputs are registered.
- Latency from accept edge to the wb_valid cycle:
  - Non-memory op or error: 1 cycle.
  - Store: 1 + grant wait + 1.
  - Load: 1 + grant wait + response wait + 1. Minimum load latency with gnt on the first REQ cycle and rvalid one cycle later is 3 cycles.
- Back-to-back non-memory ops are accepted every cycle at full throughput.
- Memory contract: dmem_rvalid arrives no earlier than the cycle after dmem_gnt, and there is at most one outstanding request.
- The writeback side has no backpressure; wb_valid is a single-cycle pulse.

## Test plan
- Non-memory ops: ex_result=0x1234 (rd=5), then 0xFFFF_FFFF (rd=0) on consecutive cycles → wb pulses on consecutive cycles: the first with wb_we=1, wb_data=0x1234; the second with wb_we=0.
- SB: addr 0x103, rs2=0xAABBCCDD → dmem_addr=0x100, wstrb=1000, wdata=0xDDDDDDDD. Hold gnt low 3 cycles: request stable, ex_ready=0. After gnt: wb_valid, wb_we=0.
- LB vs LBU: addr 0x202, rdata=0x0080_0000 → LB gives wb_data=0xFFFF_FF80; LBU gives 0x0000_0080. LH at 0x202 with rdata=0x8001_0000 gives 0xFFFF_8001.
- Misaligned: LW at 0x301 or SH at 0x305 → no dmem_req, wb_valid with mem_err=1 one cycle after accept, wb_we=0.
- Reset mid-load: assert rst_n low while in WAIT → dmem_req=0, all outputs at reset values. A stray rvalid after release produces no wb_valid.
- Response ordering: a rvalid pulse while in REQ is ignored. The load completes only on a rvalid that arrives in WAIT, with wb_data taken from that cycle's rdata.
